// File: rtl/pipe_dest_tracker_if.sv
// pipe_dest_tracker_if: groups the ID-stage issue inputs, the hazard-unit
// controls and the per-stage destination-tag outputs of pipe_dest_tracker.
// master = pipeline/hazard side driving ID fields, slave = the tracker itself.
interface pipe_dest_tracker_if #(
  parameter int CNT_W = 16
);
  // ID-stage instruction and hazard-unit controls
  logic             id_valid;
  logic [2:0]       id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             stall;
  logic             redirect;
  // Per-stage tags and status
  logic [2:0]       IDEX_rd;
  logic [2:0]       EXMEM_rd;
  logic [2:0]       MEMWB_rd;
  logic [2:0]       WB_rd;
  logic             IDEX_MemRead;
  logic             EXMEM_RegWrite;
  logic             MEMWB_RegWrite;
  logic             WB_RegWrite;
  logic             pipe_empty;
  logic [CNT_W-1:0] retire_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rd, id_regwrite, id_memread, stall, redirect,
    input  IDEX_rd, EXMEM_rd, MEMWB_rd, WB_rd, IDEX_MemRead,
           EXMEM_RegWrite, MEMWB_RegWrite, WB_RegWrite, pipe_empty,
           retire_count, stall_count
  );

  modport slave (
    input  id_valid, id_rd, id_regwrite, id_memread, stall, redirect,
    output IDEX_rd, EXMEM_rd, MEMWB_rd, WB_rd, IDEX_MemRead,
           EXMEM_RegWrite, MEMWB_RegWrite, WB_RegWrite, pipe_empty,
           retire_count, stall_count
  );
endinterface

// File: rtl/pipe_dest_tracker.sv
// pipe_dest_tracker: four-stage (IDEX/EXMEM/MEMWB/WB) destination-tag pipeline
// feeding the hazard/forwarding unit; applies load-use bubbles and redirect kills.
// Latency 1..4 cycles ID->stage; never back-pressures, only IDEX takes bubbles.
// Ports: clk, reset_n (async active-low), bus (slave modport): ID fields,
// stall, redirect in; stage tags, write/read flags, pipe_empty, counters out.
module pipe_dest_tracker #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  pipe_dest_tracker_if.slave bus
);

  typedef struct packed {
    logic       vld;
    logic [2:0] rd;
    logic       regwrite;
  } tag_t;

  // The load flag only matters while the entry sits in IDEX (that is where
  // the hazard unit looks for load-use), so later stages do not carry it.
  tag_t             r_idex;
  logic             r_idex_memread;
  tag_t             r_exmem;
  tag_t             r_memwb;
  tag_t             r_wb;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  tag_t             w_id_tag;
  logic             w_idex_kill;
  logic             w_stall_cnt_en;

  assign w_id_tag       = '{vld: bus.id_valid, rd: bus.id_rd, regwrite: bus.id_regwrite};
  // Redirect and stall both refuse the ID instruction; redirect wins for counting.
  assign w_idex_kill    = bus.redirect | bus.stall;
  assign w_stall_cnt_en = bus.stall & ~bus.redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idex         <= '0;
      r_idex_memread <= 1'b0;
      r_exmem        <= '0;
      r_memwb        <= '0;
      r_wb           <= '0;
      r_retire_cnt   <= '0;
      r_stall_cnt    <= '0;
    end else begin
      r_idex         <= w_idex_kill ? '0 : w_id_tag;
      r_idex_memread <= w_idex_kill ? 1'b0 : bus.id_memread;
      // On redirect the instruction in IDEX is younger than the branch and dies.
      r_exmem        <= bus.redirect ? '0 : r_idex;
      r_memwb        <= r_exmem;
      r_wb           <= r_memwb;

      if (r_wb.vld && (r_retire_cnt != '1)) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
      if (w_stall_cnt_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.IDEX_rd        = r_idex.vld  ? r_idex.rd  : 3'b000;
  assign bus.EXMEM_rd       = r_exmem.vld ? r_exmem.rd : 3'b000;
  assign bus.MEMWB_rd       = r_memwb.vld ? r_memwb.rd : 3'b000;
  assign bus.WB_rd          = r_wb.vld    ? r_wb.rd    : 3'b000;
  assign bus.IDEX_MemRead   = r_idex.vld  & r_idex_memread;
  assign bus.EXMEM_RegWrite = r_exmem.vld & r_exmem.regwrite;
  assign bus.MEMWB_RegWrite = r_memwb.vld & r_memwb.regwrite;
  assign bus.WB_RegWrite    = r_wb.vld    & r_wb.regwrite;
  assign bus.pipe_empty     = ~(r_idex.vld | r_exmem.vld | r_memwb.vld | r_wb.vld);
  assign bus.retire_count   = r_retire_cnt;
  assign bus.stall_count    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Bench for pipe_dest_tracker: history-based model compared every cycle,
// plus hand-computed literal checks for the directed scenarios.
module tb_pipe_dest_tracker;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipe_dest_tracker_if #(.CNT_W(CNT_W)) bus ();
  pipe_dest_tracker #(.CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Model ----------------
  // cap[k] = what the ID stage handed over at the k-th edge since reset
  // release. An entry captured at edge k is seen in stage s after edge k+s;
  // a redirect at edge k kills the entry captured at edge k-1.
  typedef struct {
    bit       v;
    bit [2:0] rd;
    bit       rw;
    bit       mr;
  } ent_t;

  ent_t cap [0:1023];
  int   n     = 0;
  int   m_ret = 0;
  int   m_stl = 0;
  ent_t m_new;
  ent_t m_old;

  function automatic ent_t stage_of(input int s);
    ent_t b;
    b = '{v: 1'b0, rd: 3'd0, rw: 1'b0, mr: 1'b0};
    if ((n - s) >= 1) return cap[n - s];
    return b;
  endfunction

  always @(negedge reset_n) begin
    n = 0; m_ret = 0; m_stl = 0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      m_old = stage_of(3);
      if (m_old.v && m_ret < CMAX) m_ret++;
      if (bus.stall && !bus.redirect && m_stl < CMAX) m_stl++;
      n++;
      m_new.v  = bus.id_valid && !bus.stall && !bus.redirect;
      m_new.rd = bus.id_rd;
      m_new.rw = bus.id_regwrite;
      m_new.mr = bus.id_memread;
      cap[n] = m_new;
      if (bus.redirect && n >= 2) cap[n-1].v = 1'b0;
    end
  end

  // ---------------- Per-cycle compare ----------------
  always @(negedge clk) begin
    ent_t e0, e1, e2, e3;
    e0 = stage_of(0); e1 = stage_of(1); e2 = stage_of(2); e3 = stage_of(3);
    chk("m_IDEX_rd",   32'(bus.IDEX_rd),  e0.v ? 32'(e0.rd) : 32'd0);
    chk("m_EXMEM_rd",  32'(bus.EXMEM_rd), e1.v ? 32'(e1.rd) : 32'd0);
    chk("m_MEMWB_rd",  32'(bus.MEMWB_rd), e2.v ? 32'(e2.rd) : 32'd0);
    chk("m_WB_rd",     32'(bus.WB_rd),    e3.v ? 32'(e3.rd) : 32'd0);
    chk("m_IDEX_MemRead",   32'(bus.IDEX_MemRead),   32'(e0.v && e0.mr));
    chk("m_EXMEM_RegWrite", 32'(bus.EXMEM_RegWrite), 32'(e1.v && e1.rw));
    chk("m_MEMWB_RegWrite", 32'(bus.MEMWB_RegWrite), 32'(e2.v && e2.rw));
    chk("m_WB_RegWrite",    32'(bus.WB_RegWrite),    32'(e3.v && e3.rw));
    chk("m_pipe_empty",     32'(bus.pipe_empty),     32'(!(e0.v || e1.v || e2.v || e3.v)));
    chk("m_retire_count",   32'(bus.retire_count),   32'(m_ret));
    chk("m_stall_count",    32'(bus.stall_count),    32'(m_stl));
  end

  // ---------------- Stimulus ----------------
  task automatic issue(input logic v, input logic [2:0] rd, input logic rw,
                       input logic mr, input logic st, input logic rdr);
    bus.id_valid = v; bus.id_rd = rd; bus.id_regwrite = rw;
    bus.id_memread = mr; bus.stall = st; bus.redirect = rdr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) issue(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state();
    chk("rst_IDEX_rd", 32'(bus.IDEX_rd), 0);
    chk("rst_EXMEM_rd", 32'(bus.EXMEM_rd), 0);
    chk("rst_MEMWB_rd", 32'(bus.MEMWB_rd), 0);
    chk("rst_WB_rd", 32'(bus.WB_rd), 0);
    chk("rst_IDEX_MemRead", 32'(bus.IDEX_MemRead), 0);
    chk("rst_EXMEM_RegWrite", 32'(bus.EXMEM_RegWrite), 0);
    chk("rst_MEMWB_RegWrite", 32'(bus.MEMWB_RegWrite), 0);
    chk("rst_WB_RegWrite", 32'(bus.WB_RegWrite), 0);
    chk("rst_pipe_empty", 32'(bus.pipe_empty), 1);
    chk("rst_retire_count", 32'(bus.retire_count), 0);
    chk("rst_stall_count", 32'(bus.stall_count), 0);
  endtask

  initial begin
    bus.id_valid = 0; bus.id_rd = 0; bus.id_regwrite = 0;
    bus.id_memread = 0; bus.stall = 0; bus.redirect = 0;
    #2;
    chk_reset_state();
    #10 reset_n = 1'b1;   // released mid-cycle; first capture at the next edge

    // Invalid ID instruction is a bubble whatever its other fields say.
    issue(1'b0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("inv_IDEX_rd", 32'(bus.IDEX_rd), 0);
    chk("inv_IDEX_MemRead", 32'(bus.IDEX_MemRead), 0);
    chk("inv_pipe_empty", 32'(bus.pipe_empty), 1);

    // Straight flow: rd=3 walks through all four stages then retires.
    issue(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sf_IDEX_rd_c1", 32'(bus.IDEX_rd), 3);
    chk("sf_pipe_empty_c1", 32'(bus.pipe_empty), 0);
    idle(1);
    chk("sf_EXMEM_rd_c2", 32'(bus.EXMEM_rd), 3);
    chk("sf_EXMEM_RegWrite_c2", 32'(bus.EXMEM_RegWrite), 1);
    idle(1);
    chk("sf_MEMWB_rd_c3", 32'(bus.MEMWB_rd), 3);
    chk("sf_MEMWB_RegWrite_c3", 32'(bus.MEMWB_RegWrite), 1);
    idle(1);
    chk("sf_WB_rd_c4", 32'(bus.WB_rd), 3);
    chk("sf_WB_RegWrite_c4", 32'(bus.WB_RegWrite), 1);
    chk("sf_retire_c4", 32'(bus.retire_count), 0);
    idle(1);
    chk("sf_retire_c5", 32'(bus.retire_count), 1);
    chk("sf_pipe_empty_c5", 32'(bus.pipe_empty), 1);

    // Load-use: load rd=2, one stall cycle holding rd=5 in ID, then rd=5 issues.
    issue(1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu_IDEX_MemRead_c1", 32'(bus.IDEX_MemRead), 1);
    chk("lu_IDEX_rd_c1", 32'(bus.IDEX_rd), 2);
    issue(1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lu_IDEX_rd_bubble", 32'(bus.IDEX_rd), 0);
    chk("lu_IDEX_MemRead_bubble", 32'(bus.IDEX_MemRead), 0);
    chk("lu_EXMEM_rd", 32'(bus.EXMEM_rd), 2);
    chk("lu_stall_count", 32'(bus.stall_count), 1);
    issue(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_IDEX_rd_after", 32'(bus.IDEX_rd), 5);
    chk("lu_MEMWB_rd", 32'(bus.MEMWB_rd), 2);
    idle(5);
    chk("lu_retire", 32'(bus.retire_count), 3);

    // Redirect: rd=1,2,3 in flight; redirect kills IDEX(3) and the ID instr.
    issue(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rd_pre_IDEX_rd", 32'(bus.IDEX_rd), 3);
    chk("rd_pre_EXMEM_rd", 32'(bus.EXMEM_rd), 2);
    issue(1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rd_IDEX_rd", 32'(bus.IDEX_rd), 0);
    chk("rd_EXMEM_rd", 32'(bus.EXMEM_rd), 0);
    chk("rd_EXMEM_RegWrite", 32'(bus.EXMEM_RegWrite), 0);
    chk("rd_MEMWB_rd", 32'(bus.MEMWB_rd), 2);
    chk("rd_WB_rd", 32'(bus.WB_rd), 1);
    idle(5);
    chk("rd_retire", 32'(bus.retire_count), 5);

    // Stall together with redirect: redirect wins, stall not counted.
    issue(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("sr_IDEX_rd", 32'(bus.IDEX_rd), 0);
    chk("sr_EXMEM_rd", 32'(bus.EXMEM_rd), 0);
    chk("sr_MEMWB_rd", 32'(bus.MEMWB_rd), 2);
    chk("sr_WB_rd", 32'(bus.WB_rd), 1);
    chk("sr_stall_count", 32'(bus.stall_count), 1);
    idle(5);
    chk("sr_retire", 32'(bus.retire_count), 7);

    // Asynchronous reset with three valid entries in flight.
    issue(1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mr_pre_pipe_empty", 32'(bus.pipe_empty), 0);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_state();
    #4 reset_n = 1'b1;
    bus.id_valid = 0; bus.id_memread = 0; bus.id_regwrite = 0; bus.id_rd = 0;
    @(posedge clk); #1;

    // Saturation: 20 retirements into a 4-bit counter; r0 write carried as-is.
    for (int i = 0; i < 20; i++) begin
      issue(1'b1, 3'(i % 8), 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 1) begin
        chk("r0_EXMEM_rd", 32'(bus.EXMEM_rd), 0);
        chk("r0_EXMEM_RegWrite", 32'(bus.EXMEM_RegWrite), 1);
      end
    end
    idle(5);
    chk("sat_retire", 32'(bus.retire_count), 15);
    chk("sat_stall", 32'(bus.stall_count), 0);
    chk("sat_pipe_empty", 32'(bus.pipe_empty), 1);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_dest_tracker.md
# pipe_dest_tracker

Tracks the destination-register tag, write-enable and load flag of every in-flight instruction from ID/EX through the write-back register stage. It is the producer of the `*_rd`, `*_RegWrite` and `IDEX_MemRead` signals that the hazard/forwarding unit consumes, and it receives that unit's `stall` back. It applies load-use bubbles and branch-redirect kills to the tag pipeline, and keeps saturating retire and stall counters for debug.

## Interface

- `CNT_W`, default 16: width of the retire and stall counters.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  the ID stage holds a real instruction this cycle.
- `id_rd`  in  3  destination register of the ID-stage instruction.
- `id_regwrite`  in  1  the ID-stage instruction writes the register file.
- `id_memread`  in  1  the ID-stage instruction is a load.
- `stall`  in  1  load-use stall from the hazard unit.
- `redirect`  in  1  taken branch or jump resolved in EX; kills younger instructions.
- `IDEX_rd`, `EXMEM_rd`, `MEMWB_rd`, `WB_rd`  out  3 each  destination tags per stage.
- `IDEX_MemRead`  out  1  ID/EX entry is a valid load.
- `EXMEM_RegWrite`, `MEMWB_RegWrite`, `WB_RegWrite`  out  1 each  valid register write pending in that stage.
- `pipe_empty`  out  1  no valid entry in any of the four stages.
- `retire_count`  out  CNT_W  valid instructions that left the WB stage (saturating).
- `stall_count`  out  CNT_W  cycles in which `stall` was sampled high (saturating).

## Operation

- There are four stage registers, IDEX → EXMEM → MEMWB → WB. Each holds `{valid, rd, regwrite, memread}`.
- Output gating:
  - `*_rd` is the stored rd when valid, else 3'b000.
  - `*_RegWrite` is `valid & regwrite`.
  - `IDEX_MemRead` is `valid & memread`.
- Per-cycle update, in priority order:
  - `redirect`=1: IDEX ← bubble; EXMEM ← bubble (this kills the entry being redirected past); MEMWB ← EXMEM; WB ← MEMWB. `stall` is ignored in this cycle.
  - `stall`=1, no redirect: IDEX ← bubble; EXMEM ← IDEX; MEMWB ← EXMEM; WB ← MEMWB. The ID instruction is not captured, because the front end holds it.
  - Otherwise: IDEX ← `{id_valid, id_rd, id_regwrite, id_memread}`; the remaining stages shift.
- A bubble has all fields 0.
- The pipeline always advances. No stage other than IDEX is ever held.
- `id_regwrite` with `id_rd`=0 is carried unchanged. Suppressing r0 writes is the consumer's job.
- `retire_count` increments when WB is valid at a clock edge (the entry is leaving). It saturates at all-ones.
- `stall_count` increments on every edge with `stall`=1 and no `redirect`. It saturates at all-ones.
- `pipe_empty` is combinational: the NOR of the four valid bits.

## Timing

- Reset (asynchronous assert, `reset_n`=0): all valid bits, fields and counters clear immediately.
  - All `*_rd` are 0, all write/read flags are 0, `pipe_empty`=1, both counts are 0.
- Reset release is synchronous to the next `clk` edge. The first capture happens on the first edge with `reset_n`=1.
- Reset asserted mid-operation drops every in-flight entry. The counters do not retain their values.
- Latency: an ID instruction appears on the IDEX outputs 1 cycle after capture, on EXMEM after 2, MEMWB after 3, WB after 4. It is counted as retired at the edge ending cycle 4.
- A load-use stall produces a 1-cycle bubble. The bubble clears `IDEX_MemRead`, so a single load causes exactly one stall cycle when the hazard unit is connected.
- When `stall` and `redirect` are both high, redirect wins. Both IDEX and EXMEM become bubbles and `stall_count` does not increment.
- All outputs except `pipe_empty` are registered or derived from registers only, so there is no combinational path from inputs to outputs.

## Test plan

- **Reset:** assert `reset_n`=0 mid-stream with three valid entries → all tags 0, all flags 0, `pipe_empty`=1, counts 0 without waiting for a clock.
- **Straight flow:** issue `rd`=3, regwrite=1 at cycle 0, then idle → `IDEX_rd`=3 in cycle 1, `EXMEM_RegWrite`=1 with `EXMEM_rd`=3 in cycle 2, MEMWB in cycle 3, WB in cycle 4, `retire_count`=1 and `pipe_empty`=1 in cycle 5.
- **Load-use:** issue load `rd`=2 (memread=1), then hold `stall`=1 for one cycle → `IDEX_MemRead`=1 in cycle 1, IDEX bubble in cycle 2 (`IDEX_rd`=0), load in EXMEM in cycle 2, `stall_count`=1.
- **Redirect:** fill with `rd`=1,2,3 on consecutive cycles, pulse `redirect` with `rd`=3 in IDEX and `rd`=2 in EXMEM → next cycle IDEX and EXMEM are bubbles, `MEMWB_rd`=2, `rd`=1 in WB; only 2 retirements total.
- **Stall+redirect:** assert both in the same cycle → identical result to redirect alone, `stall_count` unchanged.
- **Saturation:** with `CNT_W`=4, run 20 valid instructions → `retire_count` holds 4'hF.
